mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Iterative multiply/divide controller for the EX stage of the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the instruction in EX and sequences a radix-2 shift-add/shift-subtract datapath over 32 iterations. It owns the architectural HI/LO registers and drives the `ready` line consumed by the hazard unit as MDUReadyE, which stalls IF/ID/EX while an operation is in flight. It aborts cleanly on an exception flush.

## Interface
- WIDTH, 32, operand width; the only supported value, with the iteration counter sized from it.

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  EX-stage instruction is an MDU op (held while stalled)
- op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 treated as NOP
- src_a  in  WIDTH  rs operand (forwarded)
- src_b  in  WIDTH  rt operand (forwarded)
- flush  in  1  exception flush (ExceptDealM); aborts the current op
- ready  out  1  0 = hold EX/ID/IF; feeds MDUReadyE
- busy  out  1  state is BUSY or DONE
- hi  out  WIDTH  architectural HI register
- lo  out  WIDTH  architectural LO register

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, start and op in {1..4} and not flush:
  - latch operand magnitudes: abs for signed ops, raw bits for unsigned ops
  - latch sign flags
  - clear counter
  - go to BUSY
- IDLE, start and op in {5,6} and not flush: write src_a into hi (MTHI) or lo (MTLO) at this edge; stay in IDLE.
- BUSY: one radix-2 step per cycle; after the step with counter = 31, go to DONE.
  - Multiply: 64-bit {acc, multiplier} shift-add on magnitudes.
  - Divide: restoring shift-subtract; remainder in the upper half, quotient in the lower half.
- DONE, sign fix-up applied combinationally:
  - product is negated if the sign flags differ
  - quotient is negated if the sign flags differ
  - remainder takes the dividend's sign
  - results commit to hi/lo at the DONE edge only if flush = 0; then go to IDLE
  - start is ignored in DONE, because the same instruction is still leaving EX
- Divide by zero (src_b = 0, either signedness): lo = all ones, hi = src_a; still takes the full 33-cycle sequence.
- flush = 1 in any state:
  - next state is IDLE
  - no hi/lo write from the aborted op or from a same-cycle MTHI/MTLO
  - counter cleared
- ready, combinational:
  - 1 if flush
  - otherwise 0 in BUSY
  - otherwise 0 in IDLE when start and op in {1..4}
  - otherwise 1
- Reset: state IDLE, counter 0, hi = lo = 0, ready = 1, busy = 0.

## Timing
- Cycle 0: MULT/DIV seen in IDLE; ready = 0.
- Cycles 1–32: BUSY; ready = 0.
- Cycle 33: DONE; ready = 1; EX advances at the end of this cycle and hi/lo commit on the same edge.
- Cycle 34: IDLE; hi/lo hold the new values, so a dependent MFHI/MFLO now in EX reads correct data without extra stall.
- Total stall: 33 cycles per MULT/DIV.
- MTHI/MTLO: 0 stall cycles; value visible the cycle after.
- Back-to-back MDU ops: the second is accepted in the first IDLE cycle after DONE.
- Flush in DONE: no commit. Reset has priority over flush and start.

## Structure
- Package mdu_pkg holds:
  - op encodings (MDU_NOP … MDU_MTLO)
  - state enum {IDLE, BUSY, DONE}
  - WIDTH-derived constant ITER_LAST = 31
- Sub-module mdu_iter_step: one combinational radix-2 step.
  - inputs: mode (mul/div), 64-bit working register, 32-bit operand
  - output: next 64-bit working register
- mdu_ctrl holds the FSM, counter, sign flags, sign fix-up and hi/lo.

## Test plan
- MULT src_a = 0xFFFFFFFD, src_b = 5 -> ready low cycles 0–32, high in cycle 33; hi = 0xFFFFFFFF, lo = 0xFFFFFFF1 from cycle 34.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001. DIVU 100/7 -> lo = 14, hi = 2. DIV 0xFFFFFFF9 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIVU 5/0 -> after 33 stall cycles, lo = 0xFFFFFFFF, hi = 5.
- Flush at BUSY cycle 10 -> ready = 1 in that cycle, IDLE next cycle, hi/lo unchanged; repeat with flush in DONE -> hi/lo unchanged.
- MTHI 0x12345678 with flush = 0 -> ready stays 1, hi = 0x12345678 next cycle; MTLO with flush = 1 -> lo unchanged.
- rst asserted mid-BUSY -> next cycle IDLE, ready = 1, busy = 0, hi = lo = 0; a new MULT started afterwards completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings and sizing for the multiply/divide unit.
package mdu_pkg;
    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = $clog2(MDU_WIDTH);
    localparam logic [MDU_CNT_W-1:0] ITER_LAST = MDU_CNT_W'(MDU_WIDTH - 1);

    typedef enum logic [2:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_e;
endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration on the {upper, lower} working register: shift-add
// multiply or restoring shift-subtract divide. Purely combinational.
module mdu_iter_step #(
    parameter int W = 32
) (
    input  logic           i_is_div,
    input  logic [2*W-1:0] i_work,
    input  logic [W-1:0]   i_opnd,
    output logic [2*W-1:0] o_work
);
    logic [W:0]     w_sum;
    logic [W:0]     w_acc;
    logic [2*W-1:0] w_mul;
    logic [W:0]     w_up;
    logic [W:0]     w_diff;
    logic           w_ge;
    logic [2*W-1:0] w_div;

    // Multiply: add multiplicand into the accumulator when the LSB is set,
    // then shift the carry-extended {acc, multiplier} right by one.
    assign w_sum = {1'b0, i_work[2*W-1:W]} + {1'b0, i_opnd};
    assign w_acc = i_work[0] ? w_sum : {1'b0, i_work[2*W-1:W]};
    assign w_mul = {w_acc, i_work[W-1:1]};

    // Divide: the partial remainder gains the next dividend bit and may
    // reach W+1 bits before the trial subtraction.
    assign w_up   = i_work[2*W-1:W-1];
    assign w_diff = w_up - {1'b0, i_opnd};
    assign w_ge   = (w_up >= {1'b0, i_opnd});
    assign w_div  = w_ge ? {w_diff[W-1:0], i_work[W-2:0], 1'b1}
                         : {w_up[W-1:0],   i_work[W-2:0], 1'b0};

    assign o_work = i_is_div ? w_div : w_mul;
endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide sequencer owning HI/LO; 33 stall cycles per
// MULT/DIV, zero for MTHI/MTLO; flush aborts without touching HI/LO.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    mdu_state_e       r_state;
    logic [CW-1:0]    r_cnt;
    logic [2*WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_opnd;
    logic             r_is_div;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_div0;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    mdu_op_e            w_op;
    logic               w_is_arith;
    logic               w_signed;
    logic               w_is_div_op;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_step;
    logic               w_neg;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_op        = mdu_op_e'(op);
    assign w_is_arith  = (w_op == MDU_MULT) || (w_op == MDU_MULTU) ||
                         (w_op == MDU_DIV)  || (w_op == MDU_DIVU);
    assign w_signed    = (w_op == MDU_MULT) || (w_op == MDU_DIV);
    assign w_is_div_op = (w_op == MDU_DIV)  || (w_op == MDU_DIVU);
    assign w_mag_a     = (w_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign w_mag_b     = (w_signed && src_b[WIDTH-1]) ? -src_b : src_b;

    mdu_iter_step #(.W(WIDTH)) u_step (
        .i_is_div (r_is_div),
        .i_work   (r_work),
        .i_opnd   (r_opnd),
        .o_work   (w_step)
    );

    // Sign fix-up on the finished magnitudes; remainder follows the dividend.
    assign w_neg    = r_sign_a ^ r_sign_b;
    assign w_prod   = w_neg ? -r_work : r_work;
    assign w_quo    = w_neg ? -r_work[WIDTH-1:0] : r_work[WIDTH-1:0];
    assign w_rem    = r_sign_a ? -r_work[2*WIDTH-1:WIDTH] : r_work[2*WIDTH-1:WIDTH];
    assign w_res_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    assign w_res_lo = r_is_div ? (r_div0 ? '1 : w_quo) : w_prod[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_work   <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (flush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && w_is_arith) begin
                        r_work   <= {{WIDTH{1'b0}}, w_mag_a};
                        r_opnd   <= w_mag_b;
                        r_is_div <= w_is_div_op;
                        r_sign_a <= w_signed && src_a[WIDTH-1];
                        r_sign_b <= w_signed && src_b[WIDTH-1];
                        r_div0   <= w_is_div_op && (src_b == '0);
                        r_cnt    <= '0;
                        r_state  <= BUSY;
                    end else if (start && w_op == MDU_MTHI) begin
                        r_hi <= src_a;
                    end else if (start && w_op == MDU_MTLO) begin
                        r_lo <= src_a;
                    end
                end
                BUSY: begin
                    r_work <= w_step;
                    if (r_cnt == ITER_LAST) begin
                        r_cnt   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // The issuing instruction is still in EX here, so start is ignored.
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ready = 1'b1;
        if (flush)
            ready = 1'b1;
        else if (r_state == BUSY)
            ready = 1'b0;
        else if (r_state == IDLE && start && w_is_arith)
            ready = 1'b0;
    end

    assign busy = (r_state == BUSY) || (r_state == DONE);
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed scoreboard bench for mdu_ctrl: expected HI/LO queued at issue,
// compared by a monitor whenever busy drops.
module tb_mdu_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        ready;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] sb_q[$];
    logic [63:0] exp_v;
    logic        prev_busy = 1'b0;
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    mdu_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .ready (ready),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] eh, input logic [31:0] el);
        sb_q.push_back({eh, el});
        m_hi = eh;
        m_lo = el;
    endtask

    // Issues a MULT/DIV-class op, counts stall cycles, returns just after the commit edge.
    task automatic arith(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
        int stall;
        start = 1'b1; op = o; src_a = a; src_b = b;
        push_exp(eh, el);
        stall = 0;
        do begin
            @(negedge clk);
            if (ready !== 1'b1) stall++;
        end while (ready !== 1'b1 && stall < 100);
        chk("stall_cycles", 32'(stall), 32'd33);
        chk("busy_in_done", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        start = 1'b0;
        op    = 3'd0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (prev_busy === 1'b1 && busy === 1'b0) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: result with no expectation at %0t", $time);
                end else begin
                    exp_v = sb_q.pop_front();
                    chk("sb_hi", hi, exp_v[63:32]);
                    chk("sb_lo", lo, exp_v[31:0]);
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        int w;
        rst = 1'b1; start = 1'b0; op = 3'd0; src_a = '0; src_b = '0; flush = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(posedge clk); #1;

        // Back-to-back arithmetic ops, each accepted in the first IDLE cycle.
        arith(3'd1, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1);
        arith(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001);
        arith(3'd4, 32'd100,       32'd7,          32'd2,         32'd14);
        arith(3'd3, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD);
        arith(3'd4, 32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF);
        arith(3'd3, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF);
        idle();

        // Flush in BUSY cycle 10.
        start = 1'b1; op = 3'd2; src_a = 32'd3; src_b = 32'd4;
        push_exp(m_hi, m_lo);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("flush_busy_ready", {31'd0, ready}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; idle();
        @(negedge clk);
        chk("flush_busy_idle", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // Flush in DONE: no commit.
        start = 1'b1; op = 3'd4; src_a = 32'd50; src_b = 32'd3;
        push_exp(m_hi, m_lo);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (ready !== 1'b1 && w < 100);
        chk("flush_done_busy", {31'd0, busy}, 32'd1);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; idle();
        @(posedge clk); #1;

        // MTHI commits with no stall; MTLO under flush is dropped.
        start = 1'b1; op = 3'd5; src_a = 32'h1234_5678;
        @(negedge clk);
        chk("mthi_ready", {31'd0, ready}, 32'd1);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk("mthi_hi", hi, 32'h1234_5678);
        m_hi = 32'h1234_5678;
        @(posedge clk); #1;
        start = 1'b1; op = 3'd6; src_a = 32'hCAFE_BABE; flush = 1'b1;
        @(posedge clk); #1;
        idle(); flush = 1'b0;
        @(negedge clk);
        chk("mtlo_flush_lo", lo, m_lo);
        @(posedge clk); #1;

        // Reset in the middle of BUSY.
        start = 1'b1; op = 3'd1; src_a = 32'd7; src_b = 32'd9;
        push_exp(32'd0, 32'd0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; idle();
        @(negedge clk);
        chk("rst_mid_ready", {31'd0, ready}, 32'd1);
        chk("rst_mid_busy",  {31'd0, busy},  32'd0);
        @(posedge clk); #1;

        arith(3'd1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2);
        idle();

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
